// File: rtl/fnd_pkg.sv
// Shared definitions for the four-digit seven-segment scanner: segment codes,
// the hex-nibble decoder and the binary-to-BCD converter state encoding.
package fnd_pkg;

  // Segment bit order is {g,f,e,d,c,b,a}; a 0 lights the segment.
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} b2b_state_t;

  function automatic logic [6:0] hex2seg(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bin2bcd.sv
// Sequential double-dabble converter: 16-bit binary to five BCD digits,
// one shift per clock, 18 busy cycles per conversion.
module bin2bcd
  import fnd_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] value,
  output logic        busy,
  output logic        done,
  output logic [19:0] bcd
);

  b2b_state_t  st;
  logic [35:0] sr;
  logic [35:0] adj;
  logic [3:0]  cnt;

  // Add-3 correction on every BCD nibble before the shift.
  always_comb begin
    adj = sr;
    for (int k = 0; k < 5; k++)
      if (sr[16+4*k +: 4] >= 4'd5) adj[16+4*k +: 4] = sr[16+4*k +: 4] + 4'd3;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st  <= IDLE;
      sr  <= '0;
      cnt <= '0;
    end else begin
      case (st)
        IDLE: if (start) begin
          sr <= {20'b0, value};
          st <= LOAD;
        end
        LOAD: begin
          cnt <= '0;
          st  <= SHIFT;
        end
        SHIFT: begin
          sr  <= adj << 1;
          cnt <= cnt + 4'd1;
          if (cnt == 4'd15) st <= DONE;
        end
        default: st <= IDLE;
      endcase
    end
  end

  assign busy = (st != IDLE);
  assign done = (st == DONE);
  assign bcd  = sr[35:16];

endmodule

// File: rtl/fnd_scanner.sv
// Four-digit multiplexed seven-segment driver: latches the GPO value, renders
// it as hex or decimal (with overflow dash and leading-zero blanking) and scans.
module fnd_scanner
  import fnd_pkg::*;
#(
  parameter int CLK_HZ  = 100_000_000,
  parameter int SCAN_HZ = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] value,
  input  logic        mode,
  input  logic        blank_lz,
  input  logic [3:0]  dp,
  input  logic        en,
  output logic [6:0]  seg,
  output logic        seg_dp,
  output logic [3:0]  an,
  output logic        busy
);

  localparam int DIV = CLK_HZ / SCAN_HZ;
  localparam int CW  = $clog2(DIV);

  logic [15:0] src_val;
  logic        src_mode;
  logic [15:0] disp;
  logic        ovf;
  logic        upd;
  logic        cv_start, cv_busy, cv_done;
  logic [19:0] cv_bcd;

  // The latch only follows the inputs while no conversion is running, so
  // changes made during a conversion are picked up once it returns to IDLE.
  assign upd      = ((value != src_val) || (mode != src_mode)) && !cv_busy;
  assign cv_start = upd && mode;
  assign busy     = cv_busy;

  bin2bcd u_b2b (
    .clk   (clk),
    .reset (reset),
    .start (cv_start),
    .value (value),
    .busy  (cv_busy),
    .done  (cv_done),
    .bcd   (cv_bcd)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src_val  <= '0;
      src_mode <= 1'b0;
      disp     <= '0;
      ovf      <= 1'b0;
    end else begin
      if (upd) begin
        src_val  <= value;
        src_mode <= mode;
        if (!mode) begin
          disp <= value;
          ovf  <= 1'b0;
        end
      end
      if (cv_done) begin
        if (cv_bcd[19:16] != 4'd0) ovf <= 1'b1;
        else begin
          ovf  <= 1'b0;
          disp <= cv_bcd[15:0];
        end
      end
    end
  end

  // Scan divider and digit index.
  logic [CW-1:0] tcnt;
  logic          tick;
  logic          live;
  logic [1:0]    idx, idx_nxt;

  assign tick    = (tcnt == CW'(DIV - 1));
  assign idx_nxt = (tick && live) ? idx + 2'd1 : idx;

  // Digit i is a leading zero when it and every digit above it are zero.
  logic [3:0] lz;
  always_comb begin
    lz    = '0;
    lz[3] = (disp[15:12] == 4'd0);
    for (int i = 2; i >= 1; i--)
      lz[i] = lz[i+1] && (disp[4*i +: 4] == 4'd0);
  end

  logic [3:0] nib;
  logic [6:0] seg_nxt;
  logic       dp_nxt;
  always_comb begin
    nib = disp[{idx_nxt, 2'b00} +: 4];
    if (ovf)                        seg_nxt = SEG_DASH;
    else if (blank_lz && lz[idx_nxt]) seg_nxt = SEG_BLANK;
    else                            seg_nxt = hex2seg(nib);
    dp_nxt = ovf ? 1'b1 : ~dp[idx_nxt];
  end

  // Outputs stay dark until the first tick, then always reflect the current digit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tcnt   <= '0;
      live   <= 1'b0;
      idx    <= 2'd0;
      seg    <= SEG_BLANK;
      seg_dp <= 1'b1;
      an     <= 4'hF;
    end else begin
      tcnt <= tick ? '0 : tcnt + 1'b1;
      if (tick) live <= 1'b1;
      idx <= idx_nxt;
      if (live || tick) begin
        seg    <= seg_nxt;
        seg_dp <= dp_nxt;
        an     <= en ? ~(4'b0001 << idx_nxt) : 4'hF;
      end
    end
  end

endmodule

// File: tb/tb_fnd_scanner.sv
// Self-checking bench for fnd_scanner (DIV = 4) against an arithmetic model of
// what each digit should show.
module tb_fnd_scanner;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] value = '0;
  logic        mode = 1'b0;
  logic        blank_lz = 1'b0;
  logic [3:0]  dp = '0;
  logic        en = 1'b0;
  logic [6:0]  seg;
  logic        seg_dp;
  logic [3:0]  an;
  logic        busy;

  int ntotal = 0;
  int npass  = 0;

  logic [6:0] segtab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic [6:0] cap_seg [4];
  logic       cap_dp  [4];
  bit         cap_seen[4];

  fnd_scanner #(.CLK_HZ(4000), .SCAN_HZ(1000)) dut (
    .clk      (clk),
    .reset    (reset),
    .value    (value),
    .mode     (mode),
    .blank_lz (blank_lz),
    .dp       (dp),
    .en       (en),
    .seg      (seg),
    .seg_dp   (seg_dp),
    .an       (an),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference: what digit i shows for number v in mode m.
  function automatic logic [6:0] model_seg(int i, int v, bit m, bit blz);
    int base, hi;
    base = m ? 10 : 16;
    if (m && v > 9999) return 7'h3F;
    hi = v / (base ** i);
    if (blz && i > 0 && hi == 0) return 7'h7F;
    return segtab[hi % base];
  endfunction

  function automatic logic model_dp(int i, int v, bit m, logic [3:0] d);
    if (m && v > 9999) return 1'b1;
    return ~d[i];
  endfunction

  function automatic int an_idx(logic [3:0] a);
    case (a)
      4'hE: return 0;
      4'hD: return 1;
      4'hB: return 2;
      4'h7: return 3;
      default: return -1;
    endcase
  endfunction

  // Wait for any running conversion to finish, then let outputs settle.
  task automatic settle(string name);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      $display("FAIL %s: busy still high after %0d cycles", name, n);
      $fatal(1);
    end
    repeat (2) @(negedge clk);
  endtask

  // Record the first observed seg/seg_dp for every digit over a bit more than a scan.
  task automatic scan_capture();
    int k;
    for (int i = 0; i < 4; i++) cap_seen[i] = 1'b0;
    repeat (5 * DIV) begin
      @(negedge clk);
      k = an_idx(an);
      if (k >= 0 && !cap_seen[k]) begin
        cap_seen[k] = 1'b1;
        cap_seg[k]  = seg;
        cap_dp[k]   = seg_dp;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    ntotal++; if (an !== 4'hF) $display("FAIL reset_an: got %h want F", an); else npass++;
    ntotal++; if (seg !== 7'h7F) $display("FAIL reset_seg: got %h want 7f", seg); else npass++;
    ntotal++; if (seg_dp !== 1'b1) $display("FAIL reset_dp: got %b want 1", seg_dp); else npass++;
    ntotal++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else npass++;
    en = 1'b1;
    reset = 1'b0;
    for (int c = 1; c <= DIV; c++) begin
      @(negedge clk);
      if (c < DIV) begin
        ntotal++; if (an !== 4'hF) $display("FAIL dark_before_tick c%0d: an=%h want F", c, an); else npass++;
      end else begin
        ntotal++; if (an !== 4'hE) $display("FAIL first_tick_an: got %h want E", an); else npass++;
        ntotal++; if (seg !== 7'h40) $display("FAIL first_tick_seg: got %h want 40", seg); else npass++;
      end
    end
  endtask

  task automatic test_hex();
    logic [6:0] want [4];
    int n;
    want = '{7'h0E, 7'h30, 7'h08, 7'h79};
    mode = 1'b0; value = 16'h1A3F; blank_lz = 1'b0; dp = 4'h0;
    repeat (3) @(negedge clk);
    n = 0;
    while (an === 4'hE && n < 20) begin @(negedge clk); n++; end
    n = 0;
    while (an !== 4'hE && n < 20) begin @(negedge clk); n++; end
    for (int k = 0; k < 4; k++) begin
      ntotal++; if (an !== ~(4'b0001 << k)) $display("FAIL hex_an%0d: got %h want %h", k, an, ~(4'b0001 << k)); else npass++;
      ntotal++; if (seg !== want[k]) $display("FAIL hex_seg%0d: got %h want %h", k, seg, want[k]); else npass++;
      ntotal++; if (seg_dp !== 1'b1) $display("FAIL hex_dp%0d: got %b want 1", k, seg_dp); else npass++;
      repeat (DIV) @(negedge clk);
    end
  endtask

  task automatic test_dec();
    logic [6:0] want [4];
    int n;
    want = '{7'h19, 7'h30, 7'h24, 7'h79};
    mode = 1'b1; value = 16'd1234;
    n = 0;
    repeat (40) begin
      @(negedge clk);
      if (busy) n++;
    end
    ntotal++; if (n != 18) $display("FAIL dec_busy_cycles: got %0d want 18", n); else npass++;
    scan_capture();
    for (int i = 0; i < 4; i++) begin
      ntotal++;
      if (!cap_seen[i] || cap_seg[i] !== want[i]) $display("FAIL dec_digit%0d: got %h want %h", i, cap_seg[i], want[i]);
      else npass++;
    end
  endtask

  task automatic test_ovf();
    value = 16'd10000; blank_lz = 1'b1; dp = 4'hF;
    settle("ovf");
    scan_capture();
    for (int i = 0; i < 4; i++) begin
      ntotal++;
      if (!cap_seen[i] || cap_seg[i] !== 7'h3F || cap_dp[i] !== 1'b1)
        $display("FAIL ovf_digit%0d: seg=%h dp=%b want 3f/1", i, cap_seg[i], cap_dp[i]);
      else npass++;
    end
    value = 16'd9999; blank_lz = 1'b0; dp = 4'h0;
    settle("9999");
    scan_capture();
    for (int i = 0; i < 4; i++) begin
      ntotal++;
      if (!cap_seen[i] || cap_seg[i] !== 7'h10) $display("FAIL max_digit%0d: got %h want 10", i, cap_seg[i]);
      else npass++;
    end
  endtask

  task automatic test_blank();
    logic [6:0] w7 [4];
    logic [6:0] w0 [4];
    w7 = '{7'h78, 7'h7F, 7'h7F, 7'h7F};
    w0 = '{7'h40, 7'h7F, 7'h7F, 7'h7F};
    mode = 1'b1; value = 16'd7; blank_lz = 1'b1; dp = 4'h0;
    settle("blank7");
    scan_capture();
    for (int i = 0; i < 4; i++) begin
      ntotal++;
      if (!cap_seen[i] || cap_seg[i] !== w7[i]) $display("FAIL blank7_digit%0d: got %h want %h", i, cap_seg[i], w7[i]);
      else npass++;
    end
    value = 16'd0;
    settle("blank0");
    scan_capture();
    for (int i = 0; i < 4; i++) begin
      ntotal++;
      if (!cap_seen[i] || cap_seg[i] !== w0[i]) $display("FAIL blank0_digit%0d: got %h want %h", i, cap_seg[i], w0[i]);
      else npass++;
    end
  endtask

  task automatic test_dp_en();
    int n;
    mode = 1'b0; value = 16'h8421; blank_lz = 1'b0; dp = 4'b0100; en = 1'b1;
    settle("dp");
    scan_capture();
    for (int i = 0; i < 4; i++) begin
      ntotal++;
      if (!cap_seen[i] || cap_dp[i] !== (i != 2)) $display("FAIL dp_digit%0d: got %b want %b", i, cap_dp[i], i != 2);
      else npass++;
    end
    n = 0;
    while (an === 4'hE && n < 20) begin @(negedge clk); n++; end
    n = 0;
    while (an !== 4'hE && n < 20) begin @(negedge clk); n++; end
    en = 1'b0;
    @(negedge clk);
    ntotal++; if (an !== 4'hF) $display("FAIL en_off: an=%h want F", an); else npass++;
    repeat (8) @(negedge clk);
    ntotal++; if (an !== 4'hF) $display("FAIL en_off_hold: an=%h want F", an); else npass++;
    @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    // The divider kept running: 11 cycles after digit 0 began, digit 2 is active.
    ntotal++; if (an !== 4'hB) $display("FAIL en_resume_an: got %h want B", an); else npass++;
    ntotal++; if (seg_dp !== 1'b0) $display("FAIL en_resume_dp: got %b want 0", seg_dp); else npass++;
  endtask

  task automatic test_back_to_back();
    int n;
    mode = 1'b1; value = 16'd1111; dp = 4'h0; blank_lz = 1'b0;
    repeat (5) @(negedge clk);
    ntotal++; if (busy !== 1'b1) $display("FAIL b2b_busy1: got %b want 1", busy); else npass++;
    value = 16'd4321;
    n = 0;
    while (busy && n < 40) begin @(negedge clk); n++; end
    @(negedge clk);
    ntotal++; if (busy !== 1'b1) $display("FAIL b2b_restart: busy=%b want 1", busy); else npass++;
    settle("b2b");
    scan_capture();
    for (int i = 0; i < 4; i++) begin
      ntotal++;
      if (!cap_seen[i] || cap_seg[i] !== model_seg(i, 4321, 1'b1, 1'b0))
        $display("FAIL b2b_digit%0d: got %h want %h", i, cap_seg[i], model_seg(i, 4321, 1'b1, 1'b0));
      else npass++;
    end
  endtask

  task automatic test_reset_mid();
    mode = 1'b1; value = 16'd5678;
    repeat (6) @(negedge clk);
    reset = 1'b1;
    #1;
    ntotal++; if (an !== 4'hF || seg !== 7'h7F || seg_dp !== 1'b1 || busy !== 1'b0)
      $display("FAIL reset_mid: an=%h seg=%h dp=%b busy=%b want F/7f/1/0", an, seg, seg_dp, busy);
    else npass++;
    @(negedge clk);
    reset = 1'b0;
    repeat (DIV) @(negedge clk);
    ntotal++; if (an !== 4'hE || seg !== 7'h40) $display("FAIL reset_mid_cleared: an=%h seg=%h want E/40", an, seg); else npass++;
    ntotal++; if (busy !== 1'b1) $display("FAIL reset_mid_reconvert: busy=%b want 1", busy); else npass++;
    settle("reset_mid");
    scan_capture();
    for (int i = 0; i < 4; i++) begin
      ntotal++;
      if (!cap_seen[i] || cap_seg[i] !== model_seg(i, 5678, 1'b1, 1'b0))
        $display("FAIL reset_mid_digit%0d: got %h want %h", i, cap_seg[i], model_seg(i, 5678, 1'b1, 1'b0));
      else npass++;
    end
  endtask

  task automatic test_random();
    int v;
    bit m, blz;
    logic [3:0] d;
    for (int it = 0; it < 12; it++) begin
      v   = $urandom_range(0, 65535);
      m   = 1'($urandom_range(0, 1));
      blz = 1'($urandom_range(0, 1));
      d   = 4'($urandom_range(0, 15));
      if (m && $urandom_range(0, 3) != 0) v = v % 10000;
      if ($urandom_range(0, 3) == 0) v = v % 100;
      value = 16'(v); mode = m; blank_lz = blz; dp = d;
      settle("random");
      scan_capture();
      for (int i = 0; i < 4; i++) begin
        ntotal++;
        if (!cap_seen[i] || cap_seg[i] !== model_seg(i, v, m, blz) || cap_dp[i] !== model_dp(i, v, m, d))
          $display("FAIL rand%0d_digit%0d: v=%0d m=%b seg=%h dp=%b want %h/%b", it, i, v, m,
                   cap_seg[i], cap_dp[i], model_seg(i, v, m, blz), model_dp(i, v, m, d));
        else npass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_hex();
    test_dec();
    test_ovf();
    test_blank();
    test_dp_en();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
